pmem_line_arbiter: RTL and testbench

//  Two-port arbiter in front of the single cacheline-wide physical memory port.

---
 rtl/pmem_line_arbiter_pkg.sv | 21 ++
 rtl/pmem_line_arbiter_if.sv | 28 ++
 rtl/pmem_line_arbiter.sv | 115 +++++++++++
 tb/tb_pmem_line_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pmem_line_arbiter_pkg.sv
// Shared types for the pmem line arbiter: grant owner and arbiter FSM state.
package pmem_line_arbiter_pkg;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } pmem_grant_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RELEASE = 2'd3
  } pmem_arb_state_t;

  // Tie-break: hand the port to whichever side did not win last time.
  function automatic pmem_grant_t other_grant(input pmem_grant_t g);
    return (g == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/pmem_line_arbiter_if.sv
// Cacheline-wide memory port bundle; master issues requests, slave answers them.
interface pmem_line_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [LINE_WIDTH-1:0] wdata;
  logic                  resp;
  logic [LINE_WIDTH-1:0] rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );

  // Read-only requester view (I-cache fill path).
  modport rd_slave (
    input  read, address,
    output resp, rdata
  );
endinterface

// File: rtl/pmem_line_arbiter.sv
// Two-requester arbiter (I-cache fill, D-cache fill/writeback) in front of the
// single cacheline pmem port; the winner owns the port until its pmem_resp.
module pmem_line_arbiter
  import pmem_line_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  pmem_line_arbiter_if.rd_slave    i_port,
  pmem_line_arbiter_if.slave       d_port,
  pmem_line_arbiter_if.master      mem_port
);

  pmem_arb_state_t state_q, state_d;
  pmem_grant_t     last_grant_q, last_grant_d;

  logic                  i_req, d_req;
  logic                  mem_read, mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  i_resp, d_resp;

  assign i_req = i_port.read;
  assign d_req = d_port.read | d_port.write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          last_grant_d = other_grant(last_grant_q);
          state_d      = (last_grant_d == GRANT_D) ? ST_SERVE_D : ST_SERVE_I;
        end else if (d_req) begin
          last_grant_d = GRANT_D;
          state_d      = ST_SERVE_D;
        end else if (i_req) begin
          last_grant_d = GRANT_I;
          state_d      = ST_SERVE_I;
        end
      end
      // An owner dropping its request early abandons the transfer without a resp.
      ST_SERVE_I: begin
        if (!i_req)             state_d = ST_IDLE;
        else if (mem_port.resp) state_d = ST_RELEASE;
      end
      ST_SERVE_D: begin
        if (!d_req)             state_d = ST_IDLE;
        else if (mem_port.resp) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      ST_SERVE_I: begin
        mem_read = 1'b1;
        mem_addr = i_port.address;
        i_resp   = mem_port.resp;
      end
      ST_SERVE_D: begin
        // Simultaneous read+write from D is resolved as a write.
        mem_read  = d_port.read & ~d_port.write;
        mem_write = d_port.write;
        mem_addr  = d_port.address;
        mem_wdata = d_port.wdata;
        d_resp    = mem_port.resp;
      end
      default: ;
    endcase
  end

  assign mem_port.read    = mem_read;
  assign mem_port.write   = mem_write;
  assign mem_port.address = mem_addr;
  assign mem_port.wdata   = mem_wdata;
  assign i_port.resp      = i_resp;
  assign d_port.resp      = d_resp;
  assign i_port.rdata     = mem_port.rdata;
  assign d_port.rdata     = mem_port.rdata;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(d_port.read && d_port.write))
        else $warning("pmem_line_arbiter: d read and write both high, issued as write");
      if (state_q == ST_SERVE_I)
        assert (i_port.read)
          else $error("pmem_line_arbiter: I request dropped before resp");
      if (state_q == ST_SERVE_D)
        assert (d_port.read || d_port.write)
          else $error("pmem_line_arbiter: D request dropped before resp");
    end
  end

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed self-checking bench for pmem_line_arbiter: cycle table plus corner sequences.
module tb_pmem_line_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam logic [AW-1:0] I_ADDR = 32'h0000_1040;
  localparam logic [AW-1:0] D_ADDR = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [LW-1:0] wpat;
  logic [LW-1:0] rpat;

  pmem_line_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) ibus ();
  pmem_line_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dbus ();
  pmem_line_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) mbus ();

  pmem_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_port   (ibus),
    .d_port   (dbus),
    .mem_port (mbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ir, dr, dw, pr;
    logic          erd, ewr;
    logic [AW-1:0] eaddr;
    logic          ews, eir, edr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ir, dr, dw, pr, erd, ewr,
                     input logic [AW-1:0] eaddr, input logic ews, eir, edr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.pr = pr;
    v.erd = erd; v.ewr = ewr; v.eaddr = eaddr;
    v.ews = ews; v.eir = eir; v.edr = edr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, dr, dw, pr);
    ibus.read  = ir;
    dbus.read  = dr;
    dbus.write = dw;
    mbus.resp  = pr;
  endtask

  task automatic chk_outs(input string tag, input logic erd, ewr,
                          input logic [AW-1:0] eaddr, input logic ews, eir, edr);
    chk({tag, " pmem_read"},    LW'(mbus.read),    LW'(erd));
    chk({tag, " pmem_write"},   LW'(mbus.write),   LW'(ewr));
    chk({tag, " pmem_address"}, LW'(mbus.address), LW'(eaddr));
    chk({tag, " pmem_wdata"},   mbus.wdata,        ews ? wpat : '0);
    chk({tag, " i_resp"},       LW'(ibus.resp),    LW'(eir));
    chk({tag, " d_resp"},       LW'(dbus.resp),    LW'(edr));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wpat = {8{32'hA5C3_0F96}};
    rpat = {8{32'h1234_5678}};
    ibus.address = I_ADDR;
    ibus.write   = 1'b0;
    ibus.wdata   = '0;
    dbus.address = D_ADDR;
    dbus.wdata   = wpat;
    mbus.rdata   = rpat;
    drive(0, 0, 0, 0);

    //            ir dr dw pr  erd ewr addr   ews eir edr
    add(0,0,0,0, 0,0,32'h0, 0,0,0);          // reset state
    add(1,0,0,0, 0,0,32'h0, 0,0,0);          // I miss: arbitration cycle
    add(1,0,0,0, 1,0,I_ADDR, 0,0,0);
    add(1,0,0,0, 1,0,I_ADDR, 0,0,0);
    add(1,0,0,0, 1,0,I_ADDR, 0,0,0);
    add(1,0,0,0, 1,0,I_ADDR, 0,0,0);
    add(1,0,0,1, 1,0,I_ADDR, 0,1,0);         // resp pulse
    add(0,0,0,0, 0,0,32'h0, 0,0,0);          // RELEASE
    add(0,0,0,0, 0,0,32'h0, 0,0,0);
    add(0,0,1,0, 0,0,32'h0, 0,0,0);          // D writeback
    add(0,0,1,0, 0,1,D_ADDR, 1,0,0);
    add(0,0,1,1, 0,1,D_ADDR, 1,0,1);
    add(0,0,0,0, 0,0,32'h0, 0,0,0);
    add(0,0,0,0, 0,0,32'h0, 0,0,0);
    add(0,0,0,1, 0,0,32'h0, 0,0,0);          // stray resp in IDLE
    add(1,1,0,0, 0,0,32'h0, 0,0,0);          // tie, last_grant=D -> I
    add(1,1,0,0, 1,0,I_ADDR, 0,0,0);
    add(1,1,0,1, 1,0,I_ADDR, 0,1,0);
    add(0,1,0,0, 0,0,32'h0, 0,0,0);          // RELEASE, D waits
    add(0,1,0,0, 0,0,32'h0, 0,0,0);          // IDLE, D seen
    add(0,1,0,0, 1,0,D_ADDR, 1,0,0);
    add(0,1,0,1, 1,0,D_ADDR, 1,0,1);
    add(0,0,0,0, 0,0,32'h0, 0,0,0);
    add(0,0,0,0, 0,0,32'h0, 0,0,0);
    add(0,1,1,0, 0,0,32'h0, 0,0,0);          // illegal read+write
    add(0,1,1,0, 0,1,D_ADDR, 1,0,0);
    add(0,1,1,1, 0,1,D_ADDR, 1,0,1);
    add(0,0,0,0, 0,0,32'h0, 0,0,0);
    add(0,0,0,0, 0,0,32'h0, 0,0,0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vq[k]) begin
      drive(vq[k].ir, vq[k].dr, vq[k].dw, vq[k].pr);
      #1;
      chk_outs($sformatf("v%0d", k), vq[k].erd, vq[k].ewr, vq[k].eaddr,
               vq[k].ews, vq[k].eir, vq[k].edr);
      next_cycle();
    end

    // Tie right after reset goes to D, then I, then next tie to D again.
    drive(0, 0, 0, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1, 1, 0, 0);
    #1 chk_outs("tie idle", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    chk_outs("tie D first", 1, 0, D_ADDR, 1, 0, 0);
    rpat = {8{32'hDEAD_BEEF}};
    mbus.rdata = rpat;
    mbus.resp  = 1'b1;
    #1 chk_outs("tie D resp", 1, 0, D_ADDR, 1, 0, 1);
    chk("tie d_rdata", dbus.rdata, rpat);
    next_cycle();
    drive(1, 0, 0, 0);
    #1 chk_outs("tie release", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    #1 chk_outs("tie idle2", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    chk_outs("tie I second", 1, 0, I_ADDR, 0, 0, 0);
    rpat = {8{32'hCAFE_F00D}};
    mbus.rdata = rpat;
    mbus.resp  = 1'b1;
    #1 chk_outs("tie I resp", 1, 0, I_ADDR, 0, 1, 0);
    chk("tie i_rdata", ibus.rdata, rpat);
    next_cycle();
    drive(0, 0, 0, 0);
    next_cycle();
    drive(1, 1, 0, 0);
    next_cycle();
    chk_outs("tie2 D", 1, 0, D_ADDR, 1, 0, 0);

    // Contention: I arrives while D owns the port; I granted 2 cycles after d_resp.
    mbus.resp = 1'b1;
    next_cycle();
    drive(0, 0, 0, 0);
    next_cycle();
    drive(0, 1, 0, 0);
    next_cycle();
    chk_outs("cont D owns", 1, 0, D_ADDR, 1, 0, 0);
    drive(1, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 chk_outs($sformatf("cont hold%0d", c), 1, 0, D_ADDR, 1, 0, 0);
      next_cycle();
    end
    mbus.resp = 1'b1;
    #1 chk_outs("cont d_resp", 1, 0, D_ADDR, 1, 0, 1);
    next_cycle();
    drive(1, 0, 0, 0);
    #1 chk_outs("cont gap1", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    #1 chk_outs("cont gap2", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    #1 chk_outs("cont I grant", 1, 0, I_ADDR, 0, 0, 0);
    mbus.resp = 1'b1;
    next_cycle();
    drive(0, 0, 0, 0);
    next_cycle();

    // Async reset during a D writeback drops pmem_write before the next edge.
    drive(0, 0, 1, 0);
    next_cycle();
    chk_outs("arst before", 0, 1, D_ADDR, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk_outs("arst during", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #1 chk_outs("arst after", 0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    chk_outs("arst idle", 0, 0, 32'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
